// File: rtl/adc_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sched_pkg
//  Description : Shared definitions for the ADC conversion scheduler.
//                - 3-bit scheduler state encoding
//                - configuration / result word widths
//                - result word reported when a conversion times out
//  Revision    : 1.0  initial release
// ============================================================================
package adc_sched_pkg;

    localparam logic [2:0]  c_IDLE           = 3'd0;
    localparam logic [2:0]  c_ARB            = 3'd1;
    localparam logic [2:0]  c_SETTLE         = 3'd2;
    localparam logic [2:0]  c_CONVERT        = 3'd3;
    localparam logic [2:0]  c_DONE           = 3'd4;

    localparam int          c_CFG_W          = 16;
    localparam int          c_RESULT_W       = 16;
    localparam logic [15:0] c_TIMEOUT_RESULT = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/adc_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : adc_rr_arbiter
//  Description : Combinational round-robin pick. Returns the first requesting
//                index at or after the pointer, wrapping to index 0.
//  Ports       : i_req       - request vector
//                i_rr_ptr    - index with highest priority this round
//                o_grant     - one-hot winner (zero when no request)
//                o_grant_idx - binary index of the winner
//  Revision    : 1.0  initial release
// ============================================================================
module adc_rr_arbiter
    import adc_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_grant_idx
);

    logic [NUM_REQ-1:0] w_upper_mask;
    logic [NUM_REQ-1:0] w_upper_req;
    logic [NUM_REQ-1:0] w_src;

    always_comb begin
        // Bits at or above the pointer win first; if none request, fall back
        // to the full vector, which realises the wrap-around.
        w_upper_mask = ~((NUM_REQ'(1) << i_rr_ptr) - NUM_REQ'(1));
        w_upper_req  = i_req & w_upper_mask;
        w_src        = (|w_upper_req) ? w_upper_req : i_req;
        // Isolate the lowest set bit.
        o_grant      = w_src & (~w_src + NUM_REQ'(1));
        o_grant_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (o_grant[i]) begin
                o_grant_idx = PTR_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_conv_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : adc_conv_scheduler
//  Description : Shares one SAR-ADC core between NUM_REQ requesters. Holds the
//                core in reset while idle, arbitrates round-robin, applies the
//                winner's config during a settle window, releases the core,
//                waits for the synchronised finish strobe (or a timeout) and
//                returns the result with a one-cycle done pulse.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                req_in            - level requests, one per requester
//                req_cfg_in        - 16-bit config word per requester
//                grant_out         - one-hot grant, held ARB..DONE
//                busy_out          - high outside IDLE
//                adc_rst_n_out     - core reset, released only in CONVERT
//                adc_config_1_out  - core config word 1
//                adc_config_2_out  - core config word 2 (tied to zero)
//                adc_fin_in        - core finish strobe (foreign domain)
//                adc_result_in     - core result
//                result_out        - captured result, valid with done_out
//                done_out          - one-cycle pulse to the granted requester
//                err_out           - one-cycle pulse with done on timeout
//  Revision    : 1.0  initial release
// ============================================================================
module adc_conv_scheduler
    import adc_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_in,
    input  logic [c_CFG_W*NUM_REQ-1:0]   req_cfg_in,
    output logic [NUM_REQ-1:0]           grant_out,
    output logic                         busy_out,
    output logic                         adc_rst_n_out,
    output logic [c_CFG_W-1:0]           adc_config_1_out,
    output logic [c_CFG_W-1:0]           adc_config_2_out,
    input  logic                         adc_fin_in,
    input  logic [c_RESULT_W-1:0]        adc_result_in,
    output logic [c_RESULT_W-1:0]        result_out,
    output logic [NUM_REQ-1:0]           done_out,
    output logic                         err_out
);

    localparam int c_PTR_W = $clog2(NUM_REQ);

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [15:0]           r_cnt;
    logic [c_PTR_W-1:0]    r_rr_ptr;
    logic [NUM_REQ-1:0]    r_grant;
    logic [c_PTR_W-1:0]    r_grant_idx;
    logic [c_CFG_W-1:0]    r_cfg;
    logic [c_RESULT_W-1:0] r_result;
    logic                  r_err;
    logic                  r_fin_s1;
    logic                  r_fin_s2;
    logic                  r_fin_prev;

    logic [NUM_REQ-1:0]    w_pick;
    logic [c_PTR_W-1:0]    w_pick_idx;
    logic [c_CFG_W-1:0]    w_pick_cfg;
    logic                  w_any_req;
    logic                  w_settle_last;
    logic                  w_timeout;
    logic                  w_fin_rise;

    adc_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_PTR_W)
    ) u_arbiter (
        .i_req       (req_in),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_pick),
        .o_grant_idx (w_pick_idx)
    );

    always_comb begin
        w_pick_cfg = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) begin
                w_pick_cfg = req_cfg_in[i*c_CFG_W +: c_CFG_W];
            end
        end
    end

    assign w_any_req     = |req_in;
    assign w_settle_last = (r_cnt == 16'(SETTLE_CYCLES - 1));
    assign w_timeout     = (r_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign w_fin_rise    = r_fin_s2 & ~r_fin_prev;

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:    if (w_any_req) w_state_nxt = c_ARB;
            c_ARB:     w_state_nxt = w_any_req ? c_SETTLE : c_IDLE;
            c_SETTLE:  if (w_settle_last) w_state_nxt = c_CONVERT;
            c_CONVERT: if (w_fin_rise || w_timeout) w_state_nxt = c_DONE;
            c_DONE:    w_state_nxt = c_IDLE;
            default:   w_state_nxt = c_IDLE;
        endcase
    end

    // State register and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_cfg       <= '0;
            r_result    <= '0;
            r_err       <= 1'b0;
            r_fin_s1    <= 1'b0;
            r_fin_s2    <= 1'b0;
            r_fin_prev  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_fin_s1 <= adc_fin_in;
            r_fin_s2 <= r_fin_s1;
            // Forcing history high while the core is in reset means a fin
            // level that is already high on entry to CONVERT is not an edge.
            r_fin_prev <= (r_state == c_SETTLE) ? 1'b1 : r_fin_s2;

            case (r_state)
                c_ARB: begin
                    r_cnt <= '0;
                    if (w_any_req) begin
                        r_grant     <= w_pick;
                        r_grant_idx <= w_pick_idx;
                        r_cfg       <= w_pick_cfg;
                    end
                end
                c_SETTLE: begin
                    r_cnt <= w_settle_last ? '0 : r_cnt + 16'd1;
                end
                c_CONVERT: begin
                    r_cnt <= r_cnt + 16'd1;
                    // A real edge takes precedence over a coincident timeout.
                    if (w_fin_rise) begin
                        r_result <= adc_result_in;
                        r_err    <= 1'b0;
                    end else if (w_timeout) begin
                        r_result <= c_TIMEOUT_RESULT;
                        r_err    <= 1'b1;
                    end
                end
                c_DONE: begin
                    r_grant  <= '0;
                    r_err    <= 1'b0;
                    r_rr_ptr <= (r_grant_idx == c_PTR_W'(NUM_REQ - 1)) ?
                                '0 : r_grant_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign grant_out        = r_grant;
    assign busy_out         = (r_state != c_IDLE);
    assign adc_rst_n_out    = (r_state == c_CONVERT);
    assign adc_config_1_out = r_cfg;
    assign adc_config_2_out = '0;
    assign result_out       = r_result;
    assign done_out         = (r_state == c_DONE) ? r_grant : '0;
    assign err_out          = (r_state == c_DONE) & r_err;

endmodule
`default_nettype wire

// File: tb/tb_adc_conv_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_conv_scheduler
//  Description : Self-checking bench for adc_conv_scheduler. Expected grant,
//                config, completion cycle, result and error flag are derived
//                from a round-robin pointer model and cycle arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adc_conv_scheduler;

    localparam int N       = 4;
    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_in;
    logic [16*N-1:0] req_cfg_in;
    logic [N-1:0]  grant_out;
    logic          busy_out;
    logic          adc_rst_n_out;
    logic [15:0]   adc_config_1_out;
    logic [15:0]   adc_config_2_out;
    logic          adc_fin_in;
    logic [15:0]   adc_result_in;
    logic [15:0]   result_out;
    logic [N-1:0]  done_out;
    logic          err_out;

    int n_checks = 0;
    int n_fails  = 0;
    int rr_ptr   = 0;

    adc_conv_scheduler #(
        .NUM_REQ        (N),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_in           (req_in),
        .req_cfg_in       (req_cfg_in),
        .grant_out        (grant_out),
        .busy_out         (busy_out),
        .adc_rst_n_out    (adc_rst_n_out),
        .adc_config_1_out (adc_config_1_out),
        .adc_config_2_out (adc_config_2_out),
        .adc_fin_in       (adc_fin_in),
        .adc_result_in    (adc_result_in),
        .result_out       (result_out),
        .done_out         (done_out),
        .err_out          (err_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Round-robin reference: first requester at or after the pointer.
    function automatic int model_pick(input logic [N-1:0] r, input int p);
        int idx;
        for (int o = 0; o < N; o++) begin
            idx = (p + o) % N;
            if (r[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic check_reset_values(input string tag);
        check_value({tag, "_grant"},  32'(grant_out), 0);
        check_value({tag, "_busy"},   32'(busy_out), 0);
        check_value({tag, "_rst_n"},  32'(adc_rst_n_out), 0);
        check_value({tag, "_cfg1"},   32'(adc_config_1_out), 0);
        check_value({tag, "_cfg2"},   32'(adc_config_2_out), 0);
        check_value({tag, "_result"}, 32'(result_out), 0);
        check_value({tag, "_done"},   32'(done_out), 0);
        check_value({tag, "_err"},    32'(err_out), 0);
    endtask

    // One complete transaction, entered and left at a negedge in IDLE.
    // rise_at : CONVERT cycle in which fin rises (-1 = never)
    // stale   : fin is (or goes) high late in SETTLE and must drop at
    //           rise_at-4 before the real rise
    // keep_fin: leave fin high after DONE
    task automatic run_conv(input logic [N-1:0] reqs, input int rise_at,
                            input logic [15:0] res, input bit stale, input bit keep_fin);
        int          w;
        int          exp_done;
        bit          exp_to;
        logic [15:0] exp_res;
        logic [15:0] exp_cfg;
        logic [31:0] exp_gnt;
        w       = model_pick(reqs, rr_ptr);
        exp_gnt = 32'(1) << w;
        exp_cfg = 16'(req_cfg_in >> (16 * w));
        if (rise_at >= 0 && rise_at + 3 <= TIMEOUT) begin
            exp_done = rise_at + 3;
            exp_to   = 1'b0;
            exp_res  = res;
        end else begin
            exp_done = TIMEOUT;
            exp_to   = 1'b1;
            exp_res  = 16'hFFFF;
        end
        req_in = reqs;
        @(negedge clk);
        check_value("arb_busy", 32'(busy_out), 1);
        check_value("arb_core_rst_n", 32'(adc_rst_n_out), 0);
        for (int s = 0; s < SETTLE; s++) begin
            @(negedge clk);
            check_value("settle_core_rst_n", 32'(adc_rst_n_out), 0);
            check_value("settle_grant", 32'(grant_out), exp_gnt);
            check_value("settle_cfg", 32'(adc_config_1_out), 32'(exp_cfg));
            check_value("settle_done", 32'(done_out), 0);
            if (stale && s == SETTLE - 2) adc_fin_in = 1'b1;
        end
        for (int k = 0; k <= exp_done; k++) begin
            @(negedge clk);
            check_value("hold_grant", 32'(grant_out), exp_gnt);
            check_value("hold_cfg", 32'(adc_config_1_out), 32'(exp_cfg));
            if (k < exp_done) begin
                check_value("conv_core_rst_n", 32'(adc_rst_n_out), 1);
                check_value("conv_done_early", 32'(done_out), 0);
                check_value("conv_busy", 32'(busy_out), 1);
                if (k == 0 && !adc_fin_in) adc_result_in = 16'($urandom);
                if (stale && k == rise_at - 4) begin
                    adc_fin_in    = 1'b0;
                    adc_result_in = 16'($urandom);
                end
                if (k == rise_at) begin
                    adc_fin_in    = 1'b1;
                    adc_result_in = res;
                end
                if (k == 1) req_cfg_in = {$urandom, $urandom};
                if (k == 2) req_in = 4'($urandom);
            end else begin
                check_value("done_vec", 32'(done_out), exp_gnt);
                check_value("done_result", 32'(result_out), 32'(exp_res));
                check_value("done_err", 32'(err_out), 32'(exp_to));
                check_value("done_core_rst_n", 32'(adc_rst_n_out), 0);
                if (!keep_fin) adc_fin_in = 1'b0;
                rr_ptr = (w + 1) % N;
            end
        end
        req_in = '0;
        @(negedge clk);
        check_value("idle_busy", 32'(busy_out), 0);
        check_value("idle_done", 32'(done_out), 0);
        check_value("idle_grant", 32'(grant_out), 0);
        check_value("idle_err", 32'(err_out), 0);
    endtask

    initial begin
        logic [15:0] saved_result;
        int          w;
        rst           = 1'b1;
        req_in        = '0;
        req_cfg_in    = '0;
        adc_fin_in    = 1'b0;
        adc_result_in = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single request with fixed config and result
        req_cfg_in = {$urandom, 16'($urandom), 16'h00C9};
        run_conv(4'b0001, 20, 16'h0ABC, 1'b0, 1'b0);

        // Move the pointer off zero before the reset test
        req_cfg_in = {$urandom, $urandom};
        run_conv(4'b0100, 5, 16'($urandom), 1'b0, 1'b0);

        // Reset in the middle of CONVERT
        req_cfg_in = {$urandom, $urandom};
        req_in     = 4'b1000;
        w          = model_pick(req_in, rr_ptr);
        repeat (1 + SETTLE + 5) @(negedge clk);
        check_value("pre_reset_core_rst_n", 32'(adc_rst_n_out), 1);
        check_value("pre_reset_grant", 32'(grant_out), 32'(1) << w);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midconv_reset");
        rst    = 1'b0;
        req_in = '0;
        rr_ptr = 0;
        repeat (4) begin
            @(negedge clk);
            check_value("post_reset_done", 32'(done_out), 0);
        end

        // Fairness: everybody requesting
        for (int i = 0; i < 8; i++) begin
            req_cfg_in = {$urandom, $urandom};
            run_conv(4'b1111, $urandom_range(0, 30), 16'($urandom), 1'b0, 1'b0);
        end

        // Timeout, then a normal conversion
        req_cfg_in = {$urandom, $urandom};
        run_conv(4'b0100, -1, 16'($urandom), 1'b0, 1'b0);
        run_conv(4'b0100, 7, 16'($urandom), 1'b0, 1'b0);

        // Edge arriving exactly as the timeout expires, and one cycle too late
        run_conv(4'($urandom_range(1, 15)), TIMEOUT - 3, 16'($urandom), 1'b0, 1'b0);
        run_conv(4'($urandom_range(1, 15)), TIMEOUT - 2, 16'($urandom), 1'b0, 1'b0);

        // Stale fin held across DONE, then fin rising at the end of SETTLE
        req_cfg_in = {$urandom, $urandom};
        run_conv(4'b0011, 10, 16'($urandom), 1'b0, 1'b1);
        run_conv(4'b0011, 12, 16'($urandom), 1'b1, 1'b0);
        run_conv(4'b1000, 12, 16'($urandom), 1'b1, 1'b0);

        // Withdrawal in ARB
        saved_result = result_out;
        req_in = 4'b1010;
        @(negedge clk);
        check_value("wd_arb_busy", 32'(busy_out), 1);
        req_in = '0;
        @(negedge clk);
        check_value("wd_idle_busy", 32'(busy_out), 0);
        check_value("wd_grant", 32'(grant_out), 0);
        repeat (SETTLE + 2) begin
            @(negedge clk);
            check_value("wd_done", 32'(done_out), 0);
            check_value("wd_busy", 32'(busy_out), 0);
        end
        check_value("wd_result_kept", 32'(result_out), 32'(saved_result));
        run_conv(4'b1010, 9, 16'($urandom), 1'b0, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 16; i++) begin
            req_cfg_in = {$urandom, $urandom};
            run_conv(4'($urandom_range(1, 15)), $urandom_range(0, 66),
                     16'($urandom), 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_conv_scheduler.md
# adc_conv_scheduler

Sequencer and round-robin arbiter that shares one `adc_core_digital` SAR-ADC instance between NUM_REQ requesters. It holds the core in reset while idle and selects a requester. It then applies that requester's configuration word, releases the core to convert, and waits for the oversampled-conversion-finished strobe. Finally it returns the 16-bit result to the granted requester with a one-cycle done pulse. It sits between the system/bus-side requesters and the core's `rst_n`, `config_1_in`, `result_out` and `conv_finished_osr_out` pins.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- SETTLE_CYCLES, 8, cycles config is applied with core held in reset before release (1..255)
- TIMEOUT_CYCLES, 4096, maximum CONVERT cycles before abort (16..65535)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_in  in  NUM_REQ  level conversion requests
- req_cfg_in  in  16*NUM_REQ  per-requester config word; slice i is bits [16i+15:16i]
- grant_out  out  NUM_REQ  one-hot grant, held from ARB through DONE
- busy_out  out  1  high in every state except IDLE
- adc_rst_n_out  out  1  drives core `rst_n`; high only in CONVERT
- adc_config_1_out  out  16  drives core `config_1_in`
- adc_config_2_out  out  16  drives core `config_2_in`; constant 0
- adc_fin_in  in  1  core `conv_finished_osr_out`, from the clk_dig_in domain
- adc_result_in  in  16  core `result_out`
- result_out  out  16  captured result, valid with done_out
- done_out  out  NUM_REQ  one-cycle pulse to granted requester
- err_out  out  1  one-cycle pulse coincident with done_out on timeout

## Operation
- FSM states: IDLE, ARB, SETTLE, CONVERT, DONE.
- IDLE: if any req_in is high, go to ARB.
- ARB (1 cycle): the round-robin arbiter picks the first requesting index at or after `rr_ptr`, wrapping. It registers grant_out and registers adc_config_1_out from that requester's slice. It clears the cycle counter and goes to SETTLE.
  - If req_in is all zero in ARB (request withdrawn), go to IDLE with grant cleared.
- SETTLE: adc_rst_n_out stays low. After SETTLE_CYCLES cycles, go to CONVERT with the counter cleared.
- CONVERT: adc_rst_n_out is high. adc_fin_in passes through a 2-flop synchronizer and a rising-edge detector.
  - On a synchronized rising edge, capture adc_result_in into result_out and go to DONE.
  - When the counter reaches TIMEOUT_CYCLES-1 with no edge, load result_out = 16'hFFFF, set the error flag and go to DONE.
- DONE (1 cycle): done_out[g] is high and err_out reflects the timeout flag. rr_ptr becomes (g+1) mod NUM_REQ. adc_rst_n_out is low. Next state is IDLE.
- Requests are level-sensitive and not latched. A requester still asserting req_in after its done competes again under round-robin. A request dropped mid-conversion does not abort the conversion.
- The config word is sampled only in ARB. Changes to req_cfg_in during a conversion have no effect.
- The edge detector's history flop is forced to 1 in SETTLE. A fin level left high from a previous conversion therefore cannot complete the next one.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0
  - grant_out 0, busy_out 0, adc_rst_n_out 0
  - adc_config_1_out 0, adc_config_2_out 0
  - result_out 0, done_out 0, err_out 0
  - synchronizer flops 0
- A rst asserted in any state returns the block to these values on the next edge. The core is immediately re-held in reset, and no done is issued for an aborted conversion.
- Latency from req_in high in IDLE (cycle t):
  - ARB at t+1, SETTLE from t+2 to t+1+SETTLE_CYCLES, CONVERT from t+2+SETTLE_CYCLES
  - DONE occurs 3 cycles after adc_fin_in first rises: 2 synchronizer cycles plus 1 capture cycle.
- adc_result_in is sampled on the same edge that leaves CONVERT. The core holds the result stable while conv_finished_osr is high.
- Simultaneous requests resolve in the single ARB cycle. A back-to-back grant to another requester takes a minimum of 2 cycles from DONE, passing through IDLE.

## Structure
- Shared package `adc_sched_pkg`: state encoding (3-bit localparams IDLE=0, ARB=1, SETTLE=2, CONVERT=3, DONE=4), CFG_W=16, RESULT_W=16, TIMEOUT_RESULT=16'hFFFF.
- Sub-module `adc_rr_arbiter`: combinational one-hot pick from req vector and rr_ptr, parameterized by NUM_REQ. The pointer register stays in the scheduler.
- The counter is 16 bits and shared between SETTLE and CONVERT.

## Test plan
- Single request: req_in=4'b0001, cfg0=16'h00C9, SETTLE_CYCLES=8, fin rises 20 cycles into CONVERT, result=16'h0ABC.
  - Required: adc_config_1_out=16'h00C9 from ARB on, and adc_rst_n_out high for exactly the CONVERT span.
  - Required: done_out=4'b0001 and result_out=16'h0ABC 3 cycles after fin rises, with err_out=0.
- Fairness: all four req_in held high for 8 conversions → grant order 0,1,2,3,0,1,2,3, with exactly one done per grant.
- Timeout: TIMEOUT_CYCLES=64, fin never rises → done_out pulses after 64 CONVERT cycles with result_out=16'hFFFF and err_out=1. The next request still succeeds.
- Stale fin: adc_fin_in held high across DONE into the next conversion → no early completion; done only after fin falls and rises again.
- Reset mid-CONVERT: rst for 1 cycle → all outputs take reset values next cycle, done_out stays 0, rr_ptr=0.
- Withdrawal and config freeze:
  - req_in dropped exactly in ARB → return to IDLE with no SETTLE and no done.
  - req_cfg_in changed during CONVERT → adc_config_1_out unchanged.
